mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port instruction/data RAM between two requesters: the CPU
//  datapath (MAR/MDR ld/st/fetch traffic issued by the control unit) and a DMA/loader port.
//  Grants one requester at a time and sequences the RAM enable, write strobe and latency wait.
//  Returns read data through a registered one-cycle ack handshake.
//  Sits between the datapath memory interface and the RAM macro.
// PARAMETERS
//  ADDR_W   9   RAM word-address width
//  DATA_W   32  data width
//  RAM_LAT  1   RAM read latency in cycles after ram_en; legal 1..4
// PORTS
//  Clock      in   1       system clock, rising edge
//  Reset      in   1       asynchronous, active-low reset
//  cpu_req    in   1       CPU request; held until cpu_ack
//  cpu_we     in   1       1=write, 0=read
//  cpu_addr   in   ADDR_W  CPU word address
//  cpu_wdata  in   DATA_W  CPU write data
//  cpu_ack    out  1       one-cycle completion pulse
//  cpu_rdata  out  DATA_W  read data; valid while cpu_ack=1, held until next CPU read completes
//  dma_req/dma_we/dma_addr/dma_wdata/dma_ack/dma_rdata  same as cpu_* for DMA port
//  ram_en     out  1       RAM access strobe, one cycle per transaction
//  ram_we     out  1       RAM write strobe, qualified by ram_en
//  ram_addr   out  ADDR_W  latched granted address
//  ram_wdata  out  DATA_W  latched granted write data
//  ram_rdata  in   DATA_W  RAM read data, valid RAM_LAT cycles after the ram_en cycle
//  busy       out  1       1 in any state other than IDLE
//  owner      out  1       current/last grant: 0=CPU, 1=DMA
// BEHAVIOUR
//  - Reset (async, Reset=0): state=IDLE; all outputs 0, including rdata regs and owner.
//    A transaction in flight is dropped: no ack is issued and the requester reissues.
//  - FSM states:
//    IDLE -> ACCESS when any req=1 at a clock edge. Requester chosen by the priority rule.
//      The chosen requester's we/addr/wdata are latched on that edge.
//    ACCESS (1 cycle): ram_en=1, ram_we=latched we -> WAIT.
//    WAIT (RAM_LAT cycles, down-counter): at the last WAIT edge, ram_rdata is captured into
//      the owner's rdata reg (reads only). -> ACK.
//    ACK (1 cycle): owner's ack=1 -> IDLE.
//  - Latency: req seen in cycle 0 -> ram_en in cycle 1 -> ack in cycle RAM_LAT+2.
//    Writes use the same timing.
//  - Requester inputs are ignored after the grant edge. Dropping req mid-transaction does not
//    abort: the RAM op completes and ack still pulses.
//  - Req still high in the cycle after ack counts as a new request. Back-to-back period is
//    RAM_LAT+3 cycles.
//  - Non-owner rdata and ack are unchanged/0 during another port's transaction.
//  - A request arriving while busy waits. Arbitration happens only in IDLE.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined:
//    - On simultaneous requests in IDLE, the port that did not own the last grant wins.
//    - After reset, the CPU wins the first tie.
//  ARB_ROUND_ROBIN_EN undefined: fixed priority, CPU always wins ties. DMA can starve.
//  - Single requests are granted identically in both builds.
// TESTING
//  1. Reset=0 mid-sim -> all outputs 0, busy=0. Reset=1 -> IDLE, no spurious ack.
//  2. RAM_LAT=1:
//     a. cpu write 0xDEADBEEF @0x010, req at cycle 0 -> ram_en=1, ram_we=1, ram_addr=0x010
//        in cycle 1; cpu_ack in cycle 3.
//     b. cpu read @0x010 -> cpu_ack in cycle 3 with cpu_rdata=0xDEADBEEF.
//  3. cpu_req and dma_req both rise in cycle 0, held -> CPU acked cycle 3, DMA acked cycle 7.
//     RR build, repeated ties -> grants alternate CPU, DMA, CPU, DMA...
//  4. dma read @0x1FF issued while the CPU is in WAIT -> DMA granted in the IDLE after the
//     CPU ack. cpu_rdata is unchanged by the DMA read.
//  5. Reset=0 during WAIT of a CPU read -> no cpu_ack. After release, the reissued read
//     completes normally.
//  6. RAM_LAT=3: read request in cycle 0 -> ram_en in cycle 1, ack in cycle 5.
//     Changing cpu_addr after cycle 0 has no effect on ram_addr.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester-side memory port: request/address/data toward the arbiter, ack/read data back.
// The requester uses the master modport and the arbiter uses the slave modport.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, output we, output addr, output wdata,
                    input  ack, input  rdata);
    modport slave  (input  req, input  we, input  addr, input  wdata,
                    output ack, output rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of a single-port RAM with RAM_LAT read latency.
// ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; otherwise the CPU always wins ties.
module mem_port_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave cpu_if,
    mem_port_arbiter_if.slave dma_if,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              busy_o,
    output logic              owner_o
);
    // state  | meaning
    // IDLE   | arbitrate; latch the winner's request on the grant edge
    // ACCESS | ram_en pulse, ram_we = latched we
    // WAIT   | RAM_LAT cycles; read data captured on the last edge
    // ACK    | owner's ack pulse
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_ACK} state_t;

    localparam logic [2:0] LAT_M1 = 3'(RAM_LAT - 1);

    state_t            state_q;
    logic [2:0]        cnt_q;
    logic              we_q;
    logic              owner_q;
    logic              ram_en_q;
    logic              ram_we_q;
    logic              busy_q;
    logic              cpu_ack_q;
    logic              dma_ack_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;
    logic              pick_dma_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic              granted_q;
`endif

    always_comb begin
        pick_dma_d = 1'b0;
        if (!cpu_if.req) begin
            pick_dma_d = dma_if.req;
        end
`ifdef ARB_ROUND_ROBIN_EN
        // granted_q keeps the first tie after reset with the CPU
        else begin
            pick_dma_d = dma_if.req & granted_q & ~owner_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            owner_q     <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            granted_q   <= 1'b0;
`endif
        end else begin
            ram_en_q  <= 1'b0;
            ram_we_q  <= 1'b0;
            cpu_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cpu_if.req || dma_if.req) begin
                        owner_q     <= pick_dma_d;
                        we_q        <= pick_dma_d ? dma_if.we    : cpu_if.we;
                        ram_we_q    <= pick_dma_d ? dma_if.we    : cpu_if.we;
                        ram_addr_q  <= pick_dma_d ? dma_if.addr  : cpu_if.addr;
                        ram_wdata_q <= pick_dma_d ? dma_if.wdata : cpu_if.wdata;
                        ram_en_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
                        granted_q   <= 1'b1;
`endif
                    end
                end
                S_ACCESS: begin
                    cnt_q   <= LAT_M1;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        if (!we_q && owner_q)  dma_rdata_q <= ram_rdata_i;
                        if (!we_q && !owner_q) cpu_rdata_q <= ram_rdata_i;
                        dma_ack_q <= owner_q;
                        cpu_ack_q <= ~owner_q;
                        state_q   <= S_ACK;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                S_ACK: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ram_en_o     = ram_en_q;
    assign ram_we_o     = ram_we_q;
    assign ram_addr_o   = ram_addr_q;
    assign ram_wdata_o  = ram_wdata_q;
    assign busy_o       = busy_q;
    assign owner_o      = owner_q;
    assign cpu_if.ack   = cpu_ack_q;
    assign cpu_if.rdata = cpu_rdata_q;
    assign dma_if.ack   = dma_ack_q;
    assign dma_if.rdata = dma_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RAM_LAT=1 instance for arbitration/reset, RAM_LAT=3 instance for latency.
module tb_mem_port_arbiter;
    localparam int AW = 9;
    localparam int DW = 32;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) c1 ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) d1 ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) c3 ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) d3 ();

    logic          ram_en1, ram_we1, busy1, owner1;
    logic [AW-1:0] ram_addr1;
    logic [DW-1:0] ram_wdata1, ram_rdata1;
    logic          ram_en3, ram_we3, busy3, owner3;
    logic [AW-1:0] ram_addr3;
    logic [DW-1:0] ram_wdata3, ram_rdata3;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cpu_if(c1), .dma_if(d1),
        .ram_en_o(ram_en1), .ram_we_o(ram_we1), .ram_addr_o(ram_addr1),
        .ram_wdata_o(ram_wdata1), .ram_rdata_i(ram_rdata1),
        .busy_o(busy1), .owner_o(owner1));

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .cpu_if(c3), .dma_if(d3),
        .ram_en_o(ram_en3), .ram_we_o(ram_we3), .ram_addr_o(ram_addr3),
        .ram_wdata_o(ram_wdata3), .ram_rdata_i(ram_rdata3),
        .busy_o(busy3), .owner_o(owner3));

    // RAM models: data appears exactly RAM_LAT cycles after the ram_en cycle, garbage otherwise
    logic [DW-1:0] mem1 [512] = '{default: '0};
    logic [DW-1:0] mem3 [512] = '{default: '0};
    logic [DW-1:0] pipe1;
    logic [DW-1:0] pipe3 [3];

    always @(posedge clk) begin
        pipe1 <= (ram_en1 && !ram_we1) ? mem1[ram_addr1] : $urandom;
        if (ram_en1 && ram_we1) mem1[ram_addr1] = ram_wdata1;
    end
    always @(posedge clk) begin
        pipe3[0] <= (ram_en3 && !ram_we3) ? mem3[ram_addr3] : $urandom;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
        if (ram_en3 && ram_we3) mem3[ram_addr3] = ram_wdata3;
    end
    assign ram_rdata1 = pipe1;
    assign ram_rdata3 = pipe3[2];

    // Reference model state
    logic [DW-1:0] exp_mem [512] = '{default: '0};
    logic [DW-1:0] exp_crd = '0;
    logic [DW-1:0] exp_drd = '0;
    bit            m_last = 1'b0;
    bit            m_any  = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One arbitration episode on the RAM_LAT=1 instance; requests issued in cycle 0.
    task automatic round(input bit uc, input bit ud, input bit cwe, input bit dwe,
                         input logic [AW-1:0] ca, input logic [AW-1:0] da,
                         input logic [DW-1:0] cw, input logic [DW-1:0] dw);
        bit both, first_dma, dma_now, en_exp;
        int ec, ed;
        both      = uc && ud;
        first_dma = both ? (RR && m_any && !m_last) : ud;
        ec = !uc ? -1 : ((both && first_dma) ? 7 : 3);
        ed = !ud ? -1 : ((both && !first_dma) ? 7 : 3);
        c1.req = uc; c1.we = cwe; c1.addr = ca; c1.wdata = cw;
        d1.req = ud; d1.we = dwe; d1.addr = da; d1.wdata = dw;
        for (int k = 1; k <= 9; k++) begin
            tick();
            en_exp = (k == 1) || (both && k == 5);
            check("ram_en", ram_en1, en_exp);
            check("busy", busy1, (k <= 3) || (both && k >= 5 && k <= 7));
            if (en_exp) begin
                dma_now = (k == 5) ? !first_dma : first_dma;
                check("ram_addr", ram_addr1, dma_now ? da : ca);
                check("ram_we", ram_we1, dma_now ? dwe : cwe);
                if (dma_now ? dwe : cwe) check("ram_wdata", ram_wdata1, dma_now ? dw : cw);
            end
            check("cpu_ack", c1.ack, k == ec);
            check("dma_ack", d1.ack, k == ed);
            if (k == ec) begin
                c1.req = 1'b0;
                if (cwe) exp_mem[ca] = cw; else exp_crd = exp_mem[ca];
            end
            if (k == ed) begin
                d1.req = 1'b0;
                if (dwe) exp_mem[da] = dw; else exp_drd = exp_mem[da];
            end
            check("cpu_rdata", c1.rdata, exp_crd);
            check("dma_rdata", d1.rdata, exp_drd);
        end
        m_any  = 1'b1;
        m_last = both ? !first_dma : ud;
        check("owner", owner1, m_last);
    endtask

    // Single CPU transaction on the RAM_LAT=3 instance; inputs scrambled after the grant edge.
    task automatic lat3(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        c3.req = 1'b1; c3.we = we; c3.addr = a; c3.wdata = d;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("l3_ram_en", ram_en3, k == 1);
            check("l3_ram_addr", ram_addr3, a);
            check("l3_busy", busy3, k <= 5);
            check("l3_ack", c3.ack, k == 5);
            if (k == 1) begin
                check("l3_ram_we", ram_we3, we);
                check("l3_ram_wdata", ram_wdata3, d);
                c3.addr = a ^ 9'h0AA; c3.we = ~we; c3.wdata = ~d;
            end
            if (k == 5) begin
                c3.req = 1'b0;
                if (!we) check("l3_rdata", c3.rdata, d);
            end
        end
    endtask

    initial begin
        logic [1:0] pat;
        c1.req = 0; c1.we = 0; c1.addr = '0; c1.wdata = '0;
        d1.req = 0; d1.we = 0; d1.addr = '0; d1.wdata = '0;
        c3.req = 0; c3.we = 0; c3.addr = '0; c3.wdata = '0;
        d3.req = 0; d3.we = 0; d3.addr = '0; d3.wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy1, 0);
        check("rst_owner", owner1, 0);
        check("rst_ram_en", ram_en1, 0);
        check("rst_cpu_rdata", c1.rdata, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // CPU write then read-back at 0x010
        round(1, 0, 1, 0, 9'h010, '0, 32'hDEADBEEF, '0);
        round(1, 0, 0, 0, 9'h010, '0, '0, '0);
        check("t2_rdata", c1.rdata, 32'hDEADBEEF);
        round(0, 1, 0, 1, '0, 9'h1FF, '0, 32'h12345678);

        // DMA read issued while the CPU read is in WAIT
        c1.req = 1; c1.we = 0; c1.addr = 9'h010;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 2) begin d1.req = 1; d1.we = 0; d1.addr = 9'h1FF; end
            check("t4_ram_en", ram_en1, (k == 1) || (k == 5));
            check("t4_cpu_ack", c1.ack, k == 3);
            check("t4_dma_ack", d1.ack, k == 7);
            if (k == 5) check("t4_ram_addr", ram_addr1, 9'h1FF);
            if (k == 3) c1.req = 0;
            if (k == 7) d1.req = 0;
        end
        check("t4_cpu_rdata", c1.rdata, 32'hDEADBEEF);
        check("t4_dma_rdata", d1.rdata, 32'h12345678);
        exp_crd = 32'hDEADBEEF; exp_drd = 32'h12345678;
        m_any = 1'b1; m_last = 1'b1;

        // Reset during WAIT of a CPU read
        c1.req = 1; c1.we = 0; c1.addr = 9'h010;
        tick(); tick();
        rst_n = 1'b0; c1.req = 0;
        #1;
        check("t5_cpu_ack", c1.ack, 0);
        check("t5_cpu_rdata", c1.rdata, 0);
        check("t5_dma_rdata", d1.rdata, 0);
        check("t5_busy", busy1, 0);
        check("t5_owner", owner1, 0);
        check("t5_ram_en", ram_en1, 0);
        check("t5_ram_addr", ram_addr1, 0);
        exp_crd = '0; exp_drd = '0; m_any = 1'b0; m_last = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t5_no_ack", c1.ack, 0);
            check("t5_idle", busy1, 0);
        end
        round(1, 0, 0, 0, 9'h010, '0, '0, '0);
        check("t5_reissue", c1.rdata, 32'hDEADBEEF);

        // Simultaneous requests, repeated ties
        for (int r = 0; r < 4; r++)
            round(1, 1, 0, 1, 9'h010, 9'(r + 32), '0, $urandom);

        // Randomized mix against the model
        for (int r = 0; r < 40; r++) begin
            pat = 2'($urandom_range(1, 3));
            round(pat[0], pat[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  9'($urandom_range(0, 15)), 9'($urandom_range(0, 15)), $urandom, $urandom);
        end

        // RAM_LAT=3 timing and input isolation after grant
        lat3(1'b1, 9'h020, 32'hCAFEF00D);
        lat3(1'b0, 9'h020, 32'hCAFEF00D);
        check("l3_owner", owner3, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
